// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU front end: RV32 major opcodes, the
// canonical NOP, and the fetch-unit state encoding.
package mcu_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {instr, pc} skid buffer for the fetch unit.
//   i_load  : capture i_instr/i_pc (entry becomes valid)
//   i_pop   : entry consumed (becomes empty)
//   i_flush : discard entry; wins over load/pop
//   o_valid/o_instr/o_pc : buffered entry
module ifu_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
    // Payload needs no reset; it is qualified by r_valid.
    if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, runs the req/ack handshake with
// instruction memory and presents {instr, pc, opcode} to decode. A one-entry
// skid buffer absorbs a stall that lands on a returning response; redirects
// flush everything and, if a request is in flight, wait out its response.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   o_imem_req/o_imem_addr  : fetch request (held until i_imem_ack)
//   i_imem_ack/i_imem_rdata : memory response
//   i_stall                 : decode cannot accept the output
//   i_redirect/i_redirect_pc: taken branch/JAL/JALR target
//   o_instr_valid/o_instr/o_instr_pc/o_opcode : decode-side output
//   o_fetch_misaligned      : sticky flag for a misaligned redirect target
module instr_fetch_unit
  import mcu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic [6:0]      o_opcode,
  output logic            o_fetch_misaligned
);
  fetch_state_e    r_state, w_next;
  // r_addr is the address on the bus; r_pc is where fetching resumes. They
  // differ only in FLUSH, where the bus must keep the old address.
  logic [XLEN-1:0] r_addr, r_pc;
  logic            r_valid, r_misaligned;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;

  logic            w_redir, w_consume, w_free;
  logic [XLEN-1:0] w_tgt;
  logic            w_skid_vld, w_skid_load, w_skid_pop;
  logic [31:0]     w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;

  assign w_redir   = i_redirect && (r_state != ST_RESET);
  assign w_consume = r_valid && !i_stall;
  assign w_free    = !r_valid || !i_stall;
  assign w_tgt     = {i_redirect_pc[XLEN-1:2], 2'b00};

  assign w_skid_load = (r_state == ST_FETCH) && i_imem_ack && !w_redir && !w_free;
  assign w_skid_pop  = (r_state == ST_HOLD) && w_consume && !w_redir;

  ifu_skid_buf #(.XLEN(XLEN)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_flush (w_redir),
    .i_instr (i_imem_rdata),
    .i_pc    (r_addr),
    .o_valid (w_skid_vld),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: w_next = ST_FETCH;
      ST_FETCH: begin
        if (w_redir)                     w_next = i_imem_ack ? ST_FETCH : ST_FLUSH;
        else if (i_imem_ack && !w_free)  w_next = ST_HOLD;
      end
      ST_HOLD:  if (w_redir || w_consume) w_next = ST_FETCH;
      ST_FLUSH: if (i_imem_ack)           w_next = ST_FETCH;
      default:  w_next = ST_RESET;
    endcase
  end

  // Outputs
  always_comb begin
    o_imem_req = 1'b0;
    if (r_state == ST_FETCH || r_state == ST_FLUSH) o_imem_req = 1'b1;
  end

  // Datapath: PC, output register, sticky misalignment flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr       <= RESET_PC;
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_instr_pc   <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_redir) begin
            r_pc <= w_tgt;
            if (i_imem_ack) r_addr <= w_tgt;  // response dropped, next request at target
          end else if (i_imem_ack) begin
            r_addr <= r_addr + XLEN'(4);
            r_pc   <= r_addr + XLEN'(4);
          end
        end
        ST_HOLD: begin
          if (w_redir) begin
            r_addr <= w_tgt;
            r_pc   <= w_tgt;
          end
        end
        ST_FLUSH: begin
          if (w_redir) r_pc <= w_tgt;
          if (i_imem_ack) r_addr <= w_redir ? w_tgt : r_pc;
        end
        default: ;
      endcase

      if (w_redir) begin
        r_valid <= 1'b0;
      end else if (r_state == ST_FETCH && i_imem_ack && w_free) begin
        r_valid    <= 1'b1;
        r_instr    <= i_imem_rdata;
        r_instr_pc <= r_addr;
      end else if (w_skid_pop && w_skid_vld) begin
        r_valid    <= 1'b1;
        r_instr    <= w_skid_instr;
        r_instr_pc <= w_skid_pc;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end

      if (w_redir && (i_redirect_pc[1:0] != 2'b00)) r_misaligned <= 1'b1;
    end
  end

  assign o_imem_addr        = r_addr;
  assign o_instr_valid      = r_valid;
  assign o_instr            = r_instr;
  assign o_instr_pc         = r_instr_pc;
  assign o_opcode           = r_instr[6:0];
  assign o_fetch_misaligned = r_misaligned;
endmodule
